// File: rtl/ppu_ram_link_pkg.sv
// Shared constants and types for the PPU-to-RAM serial link.
// Build option PPU_RAM_LINK_SYNC_EN adds an input register on data_pins.
package ppu_ram_link_pkg;

    localparam int RAM_PINS_DEF  = 4;
    localparam int ADDR_BITS_DEF = 16;
    localparam int DATA_BITS_DEF = 16;
    localparam int LATENCY_DEF   = 8;
    localparam logic [3:0] START_NIBBLE_DEF = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_ADDR = 2'd2
    } send_state_e;

    // Width of a nibble index that must reach max(n,m)-1; never narrower than one bit.
    function automatic int nib_cnt_w(input int n, input int m);
        int mx;
        mx = (n > m) ? n : m;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/ppu_ram_link_if.sv
// Request/response and pin-bus bundle between the PPU fetch logic, the link and the RAM pins.
interface ppu_ram_link_if #(
    parameter int RAM_PINS  = 4,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr;
    logic [RAM_PINS-1:0]  addr_pins;
    logic [RAM_PINS-1:0]  data_pins;
    logic [DATA_BITS-1:0] rdata;
    logic                 rdata_valid;
    logic                 busy;

    modport master (
        output req_valid, req_addr, data_pins,
        input  req_ready, addr_pins, rdata, rdata_valid, busy
    );

    modport slave (
        input  req_valid, req_addr, data_pins,
        output req_ready, addr_pins, rdata, rdata_valid, busy
    );
endinterface

// File: rtl/ppu_ram_link_rx.sv
// Return path: latency pipeline from the frame-start strobe, nibble capture and word assembly.
// With PPU_RAM_LINK_SYNC_EN defined, data_pins is registered once and every sample point moves one cycle later.
module ppu_ram_link_rx
    import ppu_ram_link_pkg::*;
#(
    parameter int RAM_PINS  = RAM_PINS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LATENCY   = LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [RAM_PINS-1:0]  i_data_pins,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic                 o_rdata_valid,
    output logic                 o_busy
);

    localparam int N  = ADDR_BITS / RAM_PINS;
    localparam int M  = DATA_BITS / RAM_PINS;
    localparam int CW = nib_cnt_w(N, M);
`ifdef PPU_RAM_LINK_SYNC_EN
    localparam int PEND_LEN = LATENCY + 1;
`else
    localparam int PEND_LEN = LATENCY;
`endif

    logic [PEND_LEN-1:0]  r_pend;
    logic                 r_cap_active;
    logic [CW-1:0]        r_cap_cnt;
    logic [DATA_BITS-1:0] r_asm;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_rdata_valid;

    logic [RAM_PINS-1:0]  w_data;
    logic                 w_pend_out;
    logic                 w_sampling;
    logic [CW-1:0]        w_idx;
    logic                 w_last;
    logic [DATA_BITS-1:0] w_next_asm;

`ifdef PPU_RAM_LINK_SYNC_EN
    logic [RAM_PINS-1:0] r_data_sync;

    // Input register on the external data bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_sync <= {RAM_PINS{1'b0}};
        end else begin
            r_data_sync <= i_data_pins;
        end
    end

    assign w_data = r_data_sync;
`else
    assign w_data = i_data_pins;
`endif

    // The pipeline tail marks nibble 0; a capture then runs M consecutive cycles.
    assign w_pend_out = r_pend[PEND_LEN-1];
    assign w_sampling = w_pend_out || r_cap_active;
    assign w_idx      = w_pend_out ? {CW{1'b0}} : r_cap_cnt;
    assign w_last     = (w_idx == CW'(M - 1));
    // Nibbles enter at the top and shift down, so nibble j ends in slot j after M samples.
    assign w_next_asm = (r_asm >> RAM_PINS) | (DATA_BITS'(w_data) << (DATA_BITS - RAM_PINS));

    // Latency pipeline, capture counter and word assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= {PEND_LEN{1'b0}};
            r_cap_active  <= 1'b0;
            r_cap_cnt     <= {CW{1'b0}};
            r_asm         <= {DATA_BITS{1'b0}};
            r_rdata       <= {DATA_BITS{1'b0}};
            r_rdata_valid <= 1'b0;
        end else begin
            r_pend <= (r_pend << 1) | PEND_LEN'(i_start);
            if (w_sampling) begin
                r_asm <= w_next_asm;
                if (w_last) begin
                    r_cap_active  <= 1'b0;
                    r_cap_cnt     <= {CW{1'b0}};
                    r_rdata       <= w_next_asm;
                    r_rdata_valid <= 1'b1;
                end else begin
                    r_cap_active  <= 1'b1;
                    r_cap_cnt     <= w_idx + CW'(1);
                    r_rdata_valid <= 1'b0;
                end
            end else begin
                r_rdata_valid <= 1'b0;
            end
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_busy        = (|r_pend) || r_cap_active;

endmodule

// File: rtl/ppu_ram_link.sv
// Serial read link: frames each request as header + LSB-first address nibbles, then collects the reply.
// Build option PPU_RAM_LINK_SYNC_EN registers data_pins before capture (reply one cycle later).
module ppu_ram_link
    import ppu_ram_link_pkg::*;
#(
    parameter int RAM_PINS  = RAM_PINS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LATENCY   = LATENCY_DEF,
    parameter logic [RAM_PINS-1:0] START_NIBBLE = RAM_PINS'(START_NIBBLE_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    ppu_ram_link_if.slave    bus
);

    localparam int N  = ADDR_BITS / RAM_PINS;
    localparam int M  = DATA_BITS / RAM_PINS;
    localparam int CW = nib_cnt_w(N, M);

    send_state_e          r_state;
    logic [CW-1:0]        r_nib_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [RAM_PINS-1:0]  r_addr_pins;

    logic w_last_nib;
    logic w_ready;
    logic w_accept;
    logic w_start;
    logic w_rx_busy;

    // Accepting on the last address nibble chains the next header with no idle cycle.
    assign w_last_nib = (r_state == ST_ADDR) && (r_nib_cnt == CW'(N - 1));
    assign w_ready    = (r_state == ST_IDLE) || w_last_nib;
    assign w_accept   = bus.req_valid && w_ready;
    assign w_start    = (r_state == ST_HDR);

    // Sender FSM; r_addr shifts right so its low nibble is always the next one to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_nib_cnt   <= {CW{1'b0}};
            r_addr      <= {ADDR_BITS{1'b0}};
            r_addr_pins <= {RAM_PINS{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_nib_cnt <= {CW{1'b0}};
                    if (w_accept) begin
                        r_state     <= ST_HDR;
                        r_addr      <= bus.req_addr;
                        r_addr_pins <= START_NIBBLE;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_addr_pins <= {RAM_PINS{1'b0}};
                    end
                end
                ST_HDR: begin
                    r_state     <= ST_ADDR;
                    r_nib_cnt   <= {CW{1'b0}};
                    r_addr_pins <= r_addr[RAM_PINS-1:0];
                    r_addr      <= r_addr >> RAM_PINS;
                end
                ST_ADDR: begin
                    if (w_last_nib) begin
                        r_nib_cnt <= {CW{1'b0}};
                        if (w_accept) begin
                            r_state     <= ST_HDR;
                            r_addr      <= bus.req_addr;
                            r_addr_pins <= START_NIBBLE;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_addr_pins <= {RAM_PINS{1'b0}};
                        end
                    end else begin
                        r_nib_cnt   <= r_nib_cnt + CW'(1);
                        r_addr_pins <= r_addr[RAM_PINS-1:0];
                        r_addr      <= r_addr >> RAM_PINS;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_nib_cnt   <= {CW{1'b0}};
                    r_addr_pins <= {RAM_PINS{1'b0}};
                end
            endcase
        end
    end

    ppu_ram_link_rx #(
        .RAM_PINS  (RAM_PINS),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .LATENCY   (LATENCY)
    ) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (w_start),
        .i_data_pins   (bus.data_pins),
        .o_rdata       (bus.rdata),
        .o_rdata_valid (bus.rdata_valid),
        .o_busy        (w_rx_busy)
    );

    assign bus.req_ready = w_ready;
    assign bus.addr_pins = r_addr_pins;
    assign bus.busy      = (r_state != ST_IDLE) || w_rx_busy;

endmodule
